mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_lat_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable 4-bit down-counter that times the fixed memory latency.
module arb_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_r;

    // Count register: load wins over decrement, stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Asserted when the count reaches zero at the coming edge.
    assign zero = en && (cnt_r == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data priority over fetch, fixed latency.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
`ifdef ARB_STARVE_GUARD_EN
    , parameter int unsigned STARVE_MAX = 3
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    arb_state_e        state_r, state_s;
    arb_owner_e        owner_r, owner_s;
    logic              arb_s, pick_if_s, done_s;
    logic              if_gnt_r, if_gnt_s, d_gnt_r, d_gnt_s;
    logic              if_valid_r, if_valid_s, d_valid_r, d_valid_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s, d_rdata_r, d_rdata_s;
    logic              mem_en_r, mem_en_s, mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

    assign arb_s = (state_r == ARB_IDLE) && (if_req || d_req);

    arb_lat_cnt u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (arb_s),
        .en       (state_r == ARB_ACCESS),
        .load_val (LAT_LOAD),
        .zero     (done_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);
    logic [3:0] starve_cnt_r;

    // Consecutive data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 4'd0;
        end else if (arb_s) begin
            if (!if_req || pick_if_s) begin
                starve_cnt_r <= 4'd0;
            end else begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Winner selection: data first unless fetch has waited too long.
    always_comb begin
        pick_if_s = if_req && (!d_req || (starve_cnt_r == STARVE_CAP));
    end
`else
    // Winner selection: strict data priority.
    always_comb begin
        pick_if_s = if_req && !d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (arb_s) state_s = ARB_ACCESS;
                else       state_s = ARB_IDLE;
            end
            ARB_ACCESS: begin
                if (done_s) state_s = ARB_IDLE;
                else        state_s = ARB_ACCESS;
            end
            default: state_s = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs; mem_* hold through the access.
    always_comb begin
        owner_s     = owner_r;
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_valid_s  = 1'b0;
        d_valid_s   = 1'b0;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        if (arb_s) begin
            mem_en_s = 1'b1;
            if (pick_if_s) begin
                owner_s     = OWN_IF;
                if_gnt_s    = 1'b1;
                mem_we_s    = 1'b0;
                mem_addr_s  = if_addr;
                mem_wdata_s = {DATA_W{1'b0}};
            end else begin
                owner_s     = OWN_D;
                d_gnt_s     = 1'b1;
                mem_we_s    = d_we;
                mem_addr_s  = d_addr;
                mem_wdata_s = d_wdata;
            end
        end else if (done_s) begin
            if (owner_r == OWN_IF) begin
                if_valid_s = 1'b1;
                if_rdata_s = mem_rdata;
            end else begin
                d_valid_s = 1'b1;
                if (!mem_we_r) d_rdata_s = mem_rdata;
                else           d_rdata_s = d_rdata_r;
            end
        end else begin
            owner_s = owner_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= OWN_IF;
            if_gnt_r    <= 1'b0;
            d_gnt_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_valid_r  <= 1'b0;
            d_valid_r   <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            owner_r     <= owner_s;
            if_gnt_r    <= if_gnt_s;
            d_gnt_r     <= d_gnt_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_valid_r  <= if_valid_s;
            d_valid_r   <= d_valid_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
        end
    end

    assign if_gnt    = if_gnt_r;
    assign d_gnt     = d_gnt_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_valid  = if_valid_r;
    assign d_valid   = d_valid_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign busy      = (state_r == ARB_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-data scoreboard and a latency-exact memory model.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [15:0] if_q[$];
    logic [15:0] d_q[$];
    logic [15:0] exp_drd;

    logic [15:0]  bmem [0:255];
    logic [255:0] wvld = '0;
    logic [3:0]   age  = 4'd0;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA127;
    endfunction

    // Memory model: data is only valid in the cycle ending at the sampling edge.
    always @(posedge clk) begin
        if (mem_en) begin
            age <= 4'd1;
            if (mem_we) begin
                bmem[mem_addr[7:0]] <= mem_wdata;
                wvld[mem_addr[7:0]] <= 1'b1;
            end
        end else if (age != 4'd0 && age != 4'd15) begin
            age <= age + 4'd1;
        end
    end
    assign mem_rdata = (age != 4'(LAT - 1)) ? 16'hDEAD :
                       (wvld[mem_addr[7:0]] ? bmem[mem_addr[7:0]] : pat({8'h00, mem_addr[7:0]}));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: each valid pulse pops the oldest expected read result.
    always @(negedge clk) begin
        if (if_valid) begin
            if (if_q.size() == 0) chk("if_spurious_valid", {15'd0, if_valid}, 16'h0000);
            else                  chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_valid) begin
            if (d_q.size() == 0) chk("d_spurious_valid", {15'd0, d_valid}, 16'h0000);
            else                 chk("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    initial begin
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        exp_drd = 16'h0000;
        tick(); tick();
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_mem_en", {15'd0, mem_en}, 16'h0000);
        chk("rst_gnts", {14'd0, if_gnt, d_gnt}, 16'h0000);
        chk("rst_valids", {14'd0, if_valid, d_valid}, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_d_rdata", d_rdata, 16'h0000);
        rst = 1'b1;
        tick();

        // Fetch read
        if_req = 1'b1; if_addr = 16'h0004; if_q.push_back(16'hA123);
        tick();
        chk("f_if_gnt", {15'd0, if_gnt}, 16'h0001);
        chk("f_mem_en", {15'd0, mem_en}, 16'h0001);
        chk("f_mem_addr", mem_addr, 16'h0004);
        chk("f_mem_we", {15'd0, mem_we}, 16'h0000);
        chk("f_busy", {15'd0, busy}, 16'h0001);
        if_req = 1'b0;
        tick();
        chk("f_gnt_pulse", {15'd0, if_gnt}, 16'h0000);
        chk("f_en_pulse", {15'd0, mem_en}, 16'h0000);
        chk("f_addr_hold", mem_addr, 16'h0004);
        chk("f_early_valid", {15'd0, if_valid}, 16'h0000);
        tick();
        chk("f_if_valid", {15'd0, if_valid}, 16'h0001);
        chk("f_busy_done", {15'd0, busy}, 16'h0000);
        tick();
        chk("f_valid_pulse", {15'd0, if_valid}, 16'h0000);

        // Data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1111;
        d_q.push_back(exp_drd);
        tick();
        chk("w_d_gnt", {15'd0, d_gnt}, 16'h0001);
        chk("w_if_gnt", {15'd0, if_gnt}, 16'h0000);
        chk("w_mem_we", {15'd0, mem_we}, 16'h0001);
        chk("w_mem_wdata", mem_wdata, 16'h1111);
        chk("w_mem_addr", mem_addr, 16'h0010);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("w_we_hold", {15'd0, mem_we}, 16'h0001);
        tick();
        chk("w_d_valid", {15'd0, d_valid}, 16'h0001);
        chk("w_rdata_kept", d_rdata, 16'h0000);

        // Data read-back, issued in the write's valid cycle
        d_req = 1'b1; d_addr = 16'h0010; exp_drd = 16'h1111; d_q.push_back(exp_drd);
        tick();
        chk("r_d_gnt", {15'd0, d_gnt}, 16'h0001);
        chk("r_mem_we", {15'd0, mem_we}, 16'h0000);
        d_req = 1'b0;
        tick(); tick();
        chk("r_d_valid", {15'd0, d_valid}, 16'h0001);

        // Simultaneous requests: data first, fetch straight after
        if_req = 1'b1; if_addr = 16'h0008; d_req = 1'b1; d_addr = 16'h0020;
        exp_drd = pat(16'h0020); d_q.push_back(exp_drd); if_q.push_back(pat(16'h0008));
        tick();
        chk("s_d_gnt", {15'd0, d_gnt}, 16'h0001);
        chk("s_if_wait", {15'd0, if_gnt}, 16'h0000);
        chk("s_mem_addr", mem_addr, 16'h0020);
        d_req = 1'b0;
        tick(); tick();
        chk("s_d_valid", {15'd0, d_valid}, 16'h0001);
        chk("s_if_not_yet", {15'd0, if_gnt}, 16'h0000);
        tick();
        chk("s_if_gnt", {15'd0, if_gnt}, 16'h0001);
        chk("s_if_addr", mem_addr, 16'h0008);
        chk("s_busy", {15'd0, busy}, 16'h0001);
        if_req = 1'b0;
        tick(); tick();
        chk("s_if_valid", {15'd0, if_valid}, 16'h0001);

        // Back-to-back fetches at PC 0 and 1
        if_req = 1'b1; if_addr = 16'h0000; if_q.push_back(pat(16'h0000));
        tick();
        chk("b_gnt0", {15'd0, if_gnt}, 16'h0001);
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 16'h0001; if_q.push_back(pat(16'h0001));
        tick();
        chk("b_valid0", {15'd0, if_valid}, 16'h0001);
        chk("b_no_gnt_in_access", {15'd0, if_gnt}, 16'h0000);
        tick();
        chk("b_gnt1", {15'd0, if_gnt}, 16'h0001);
        chk("b_addr1", mem_addr, 16'h0001);
        if_req = 1'b0;
        tick();
        chk("b_gap", {15'd0, if_valid}, 16'h0000);
        tick();
        chk("b_valid1", {15'd0, if_valid}, 16'h0001);

        // Starvation: continuous data requests with fetch waiting
        if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_addr = 16'h0030;
        exp_drd = pat(16'h0030);
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 3; k++) d_q.push_back(exp_drd);
        if_q.push_back(pat(16'h0040));
`else
        for (int k = 0; k < 4; k++) d_q.push_back(exp_drd);
`endif
        for (int g = 0; g < 4; g++) begin
            tick();
`ifdef ARB_STARVE_GUARD_EN
            if (g == 3) begin
                chk("st_if_gnt", {14'd0, if_gnt, d_gnt}, 16'h0002);
            end else begin
                chk("st_d_gnt", {14'd0, if_gnt, d_gnt}, 16'h0001);
            end
`else
            chk("st_d_gnt", {14'd0, if_gnt, d_gnt}, 16'h0001);
`endif
            if (g == 3) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            tick(); tick();
        end
        tick();

        // Reset in the middle of an access
        d_req = 1'b1; d_addr = 16'h0050;
        tick();
        chk("x_d_gnt", {15'd0, d_gnt}, 16'h0001);
        d_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("x_gnt_clr", {14'd0, if_gnt, d_gnt}, 16'h0000);
        chk("x_mem_en_clr", {15'd0, mem_en}, 16'h0000);
        chk("x_mem_addr_clr", mem_addr, 16'h0000);
        chk("x_busy_clr", {15'd0, busy}, 16'h0000);
        chk("x_d_rdata_clr", d_rdata, 16'h0000);
        chk("x_if_rdata_clr", if_rdata, 16'h0000);
        exp_drd = 16'h0000;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("x_no_valid", {14'd0, if_valid, d_valid}, 16'h0000);
        end

        chk("if_q_drained", 16'(if_q.size()), 16'h0000);
        chk("d_q_drained", 16'(d_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
